// File: rtl/bcd_digit_splitter.sv
// bcd_digit_splitter: sequential binary-to-BCD converter feeding the two
// 7-segment digit decoders. A captured value (clamped to CLAMP_MAX) is run
// through WIDTH shift-add-3 iterations. The finished tens and ones digits are
// then registered onto the outputs together with a one-cycle o_Done pulse.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for i_Start; outputs hold the last converted result
//   S_SHIFT | one add-3 + shift iteration per clock, WIDTH iterations total
//   S_DONE  | copy nibbles/overflow to outputs, pulse o_Done, back to idle

module bcd_digit_splitter #(
    parameter int WIDTH     = 7,
    parameter int CLAMP_MAX = 99
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Start,
    input  logic [WIDTH-1:0] i_Value,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [6:0]       o_Tens,
    output logic [6:0]       o_Ones,
    output logic             o_Overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] CLAMP_VAL = WIDTH'(CLAMP_MAX);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   iter_cnt;
    logic [WIDTH-1:0]   bin_reg;
    logic [3:0]         tens_nib;
    logic [3:0]         ones_nib;
    logic               ovf_latch;

    logic               value_ovf;
    logic [WIDTH-1:0]   value_clamped;
    logic [3:0]         tens_adj;
    logic [3:0]         ones_adj;
    logic [WIDTH+7:0]   shifted;

    // Clamp the incoming value and flag when clamping was needed.
    always_comb begin
        value_ovf     = (i_Value > CLAMP_VAL);
        value_clamped = value_ovf ? CLAMP_VAL : i_Value;
    end

    // One double-dabble step: correct nibbles >= 5, then shift the whole
    // {tens, ones, bin} chain left so the binary MSB enters the ones LSB.
    always_comb begin
        tens_adj = (tens_nib >= 4'd5) ? (tens_nib + 4'd3) : tens_nib;
        ones_adj = (ones_nib >= 4'd5) ? (ones_nib + 4'd3) : ones_nib;
        shifted  = {tens_adj, ones_adj, bin_reg} << 1;
    end

    // Conversion controller; all outputs are registered here.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= S_IDLE;
            iter_cnt   <= '0;
            bin_reg    <= '0;
            tens_nib   <= '0;
            ones_nib   <= '0;
            ovf_latch  <= 1'b0;
            o_Busy     <= 1'b0;
            o_Done     <= 1'b0;
            o_Tens     <= '0;
            o_Ones     <= '0;
            o_Overflow <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        bin_reg   <= value_clamped;
                        ovf_latch <= value_ovf;
                        tens_nib  <= '0;
                        ones_nib  <= '0;
                        iter_cnt  <= '0;
                        o_Busy    <= 1'b1;
                        state     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    tens_nib <= shifted[WIDTH+7:WIDTH+4];
                    ones_nib <= shifted[WIDTH+3:WIDTH];
                    bin_reg  <= shifted[WIDTH-1:0];
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_CNT) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    o_Tens     <= {3'b000, tens_nib};
                    o_Ones     <= {3'b000, ones_nib};
                    o_Overflow <= ovf_latch;
                    o_Done     <= 1'b1;
                    o_Busy     <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    o_Busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
